// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: merges inst and data sram-like requesters onto one master port.
// At most one transaction is in flight, and its grant holds from IDLE exit until it completes.
module cpu_sram_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic grant;
  logic inAddr, inData;
  assign inAddr = state == ADDR;
  assign inData = state == DATA;
  // Strobes outside their phase are flagged and never forwarded or acted on.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      grant     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= proto_err | (m_data_ok & ~inData) | (m_addr_ok & ~inAddr);
      case (state)
        IDLE: if (inst_req | data_req) begin
          grant <= data_req & (DATA_FIRST | ~inst_req);
          state <= ADDR;
        end
        ADDR: if (m_addr_ok) state <= DATA;
        DATA: if (m_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_comb begin
    m_req        = inAddr;
    m_wr         = inAddr & (grant ? data_wr : inst_wr);
    m_size       = inAddr ? (grant ? data_size : inst_size) : 2'd0;
    m_addr       = inAddr ? (grant ? data_addr : inst_addr) : 32'd0;
    m_wdata      = inAddr ? (grant ? data_wdata : inst_wdata) : 32'd0;
    inst_addr_ok = inAddr & ~grant & m_addr_ok;
    data_addr_ok = inAddr & grant & m_addr_ok;
    inst_data_ok = inData & ~grant & m_data_ok;
    data_data_ok = inData & grant & m_data_ok;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
  end
endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb_cpu_sram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// A second instance with inst priority is checked on the simultaneous-request case.
module tb_cpu_sram_arbiter;
  localparam bit DATA_FIRST = 1'b1;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic instReq = 0, dataReq = 0, instWr = 0, dataWr = 0, mAddrOk = 0, mDataOk = 0;
  logic [1:0] instSize = 0, dataSize = 0;
  logic [31:0] instAddr = 0, dataAddr = 0, instWdata = 0, dataWdata = 0, mRdata = 0;
  logic instAddrOk, dataAddrOk, instDataOk, dataDataOk, mReq, mWr, protoErr;
  logic [1:0] mSize;
  logic [31:0] instRdata, dataRdata, mAddr, mWdata;
  logic bInstAddrOk, bDataAddrOk, bInstDataOk, bDataDataOk, bMReq, bMWr, bProtoErr;
  logic [1:0] bMSize;
  logic [31:0] bInstRdata, bDataRdata, bMAddr, bMWdata;
  cpu_sram_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(instReq), .inst_wr(instWr), .inst_size(instSize), .inst_addr(instAddr), .inst_wdata(instWdata),
    .inst_addr_ok(instAddrOk), .inst_data_ok(instDataOk), .inst_rdata(instRdata),
    .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize), .data_addr(dataAddr), .data_wdata(dataWdata),
    .data_addr_ok(dataAddrOk), .data_data_ok(dataDataOk), .data_rdata(dataRdata),
    .m_req(mReq), .m_wr(mWr), .m_size(mSize), .m_addr(mAddr), .m_wdata(mWdata),
    .m_addr_ok(mAddrOk), .m_data_ok(mDataOk), .m_rdata(mRdata), .proto_err(protoErr));
  cpu_sram_arbiter #(.DATA_FIRST(1'b0)) dutInstFirst (
    .clk(clk), .resetn(resetn),
    .inst_req(instReq), .inst_wr(instWr), .inst_size(instSize), .inst_addr(instAddr), .inst_wdata(instWdata),
    .inst_addr_ok(bInstAddrOk), .inst_data_ok(bInstDataOk), .inst_rdata(bInstRdata),
    .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize), .data_addr(dataAddr), .data_wdata(dataWdata),
    .data_addr_ok(bDataAddrOk), .data_data_ok(bDataDataOk), .data_rdata(bDataRdata),
    .m_req(bMReq), .m_wr(bMWr), .m_size(bMSize), .m_addr(bMAddr), .m_wdata(bMWdata),
    .m_addr_ok(mAddrOk), .m_data_ok(mDataOk), .m_rdata(mRdata), .proto_err(bProtoErr));
  int checks = 0, errors = 0, cyc = 0, lastIssue = -100;
  // Model: one optional in-flight transaction, its owner, and whether its address was taken.
  bit busy = 0, accepted = 0, owner = 0, expErr = 0, justAccepted = 0, prevMReq = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    bit ea, ed;
    #2;
    ea = busy && !accepted;
    ed = busy && accepted;
    chk("m_req", 32'(mReq), 32'(ea));
    chk("m_wr", 32'(mWr), 32'(ea && (owner ? dataWr : instWr)));
    chk("m_size", 32'(mSize), 32'(ea ? (owner ? dataSize : instSize) : 2'd0));
    chk("m_addr", mAddr, ea ? (owner ? dataAddr : instAddr) : 32'd0);
    chk("m_wdata", mWdata, ea ? (owner ? dataWdata : instWdata) : 32'd0);
    chk("inst_addr_ok", 32'(instAddrOk), 32'(ea && !owner && mAddrOk));
    chk("data_addr_ok", 32'(dataAddrOk), 32'(ea && owner && mAddrOk));
    chk("inst_data_ok", 32'(instDataOk), 32'(ed && !owner && mDataOk));
    chk("data_data_ok", 32'(dataDataOk), 32'(ed && owner && mDataOk));
    chk("inst_rdata", instRdata, mRdata);
    chk("data_rdata", dataRdata, mRdata);
    chk("proto_err", 32'(protoErr), 32'(expErr));
    if (mReq && !prevMReq) begin
      chk("issue_gap_ge3", 32'((cyc - lastIssue) >= 3), 32'd1);
      lastIssue = cyc;
    end
    prevMReq = mReq;
    expErr = expErr || (mDataOk && !ed) || (mAddrOk && !ea);
    justAccepted = 0;
    if (!busy) begin
      if (instReq || dataReq) begin
        busy = 1;
        accepted = 0;
        owner = dataReq && (DATA_FIRST || !instReq);
      end
    end else if (!accepted) begin
      if (mAddrOk) begin
        accepted = 1;
        justAccepted = 1;
      end
    end else if (mDataOk) busy = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic doReset();
    #2;
    resetn = 0;
    #1;
    chk("rst_m_req", 32'(mReq), 32'd0);
    chk("rst_proto_err", 32'(protoErr), 32'd0);
    chk("rst_inst_first_outs", 32'({bInstAddrOk, bDataAddrOk, bInstDataOk, bDataDataOk, bMReq, bMWr, bMSize, bProtoErr}), 32'd0);
    {instReq, dataReq, mAddrOk, mDataOk} = '0;
    {busy, accepted, owner, expErr, justAccepted, prevMReq} = '0;
    lastIssue = -100;
    @(posedge clk);
    #1;
    resetn = 1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk);
    #1;
    chk("reset_outs", 32'({mReq, mWr, instAddrOk, dataAddrOk, instDataOk, dataDataOk, protoErr}), 32'd0);
    chk("reset_m_addr", mAddr, 32'd0);
    resetn = 1;
    // Single inst read: addr_ok one cycle after m_req, data_ok two cycles later.
    instReq = 1; instWr = 0; instSize = 2; instAddr = 32'hBFC00000;
    step();
    step();
    mAddrOk = 1;
    #1 chk("d031_m_addr", mAddr, 32'hBFC00000);
    step();
    instReq = 0; mAddrOk = 0;
    step();
    mDataOk = 1; mRdata = 32'h3C1D0000;
    #1 chk("d031_inst_rdata", instRdata, 32'h3C1D0000);
    chk("d031_inst_data_ok", 32'(instDataOk), 32'd1);
    step();
    mDataOk = 0;
    step();
    // Simultaneous requests: data wins here, inst wins on the other instance.
    instReq = 1; instAddr = 32'hBFC00040;
    dataReq = 1; dataWr = 1; dataAddr = 32'h80001000; dataWdata = 32'h12345678; dataSize = 2;
    step();
    #1 chk("d032_m_wr", 32'(mWr), 32'd1);
    chk("d032_m_wdata", mWdata, 32'h12345678);
    chk("d033_m_addr", bMAddr, 32'hBFC00040);
    chk("d033_m_wr", 32'(bMWr), 32'd0);
    chk("d033_m_wdata", bMWdata, 32'd0);
    chk("d033_rdata", bInstRdata ^ bDataRdata, 32'd0);
    step();
    mAddrOk = 1;
    step();
    dataReq = 0; mAddrOk = 0; mDataOk = 1; mRdata = 32'h0BADF00D;
    step();
    mDataOk = 0;
    step();
    #1 chk("d032_inst_second", mAddr, 32'hBFC00040);
    mAddrOk = 1;
    step();
    instReq = 0; mAddrOk = 0; mDataOk = 1;
    step();
    mDataOk = 0;
    step();
    // Stalled address phase.
    instReq = 1; instAddr = 32'hBFC01234;
    step();
    repeat (10) step();
    mAddrOk = 1;
    step();
    instReq = 0; mAddrOk = 0;
    step();
    mDataOk = 1;
    step();
    mDataOk = 0;
    // Spurious data_ok in IDLE, then reset mid-ADDR.
    mDataOk = 1;
    step();
    mDataOk = 0;
    step();
    dataReq = 1; dataWr = 0; dataAddr = 32'h80002000;
    step();
    #1 chk("d035_pre_m_req", 32'(mReq), 32'd1);
    chk("d035_pre_proto_err", 32'(protoErr), 32'd1);
    step();
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (justAccepted) begin
        if (owner) dataReq = 0;
        else instReq = 0;
      end
      if (!instReq && $urandom_range(0, 3) == 0) begin
        instReq = 1; instWr = 1'($urandom); instSize = 2'($urandom_range(0, 2));
        instAddr = $urandom; instWdata = $urandom;
      end
      if (!dataReq && $urandom_range(0, 3) == 0) begin
        dataReq = 1; dataWr = 1'($urandom); dataSize = 2'($urandom_range(0, 2));
        dataAddr = $urandom; dataWdata = $urandom;
      end
      mAddrOk = (busy && !accepted) ? 1'($urandom) : 1'b0;
      mDataOk = (busy && accepted) ? 1'($urandom) : 1'b0;
      mRdata = $urandom;
      if (i >= 2000 && $urandom_range(0, 15) == 0) mDataOk = 1;
      if (i >= 2500 && $urandom_range(0, 15) == 0) mAddrOk = 1;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
